// File: rtl/instr_decode_stage_if.sv
// instr_decode_stage_if: fetch, register-bank, writeback and execute signals of the decode stage.
interface instr_decode_stage_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              if_valid;
   logic [31:0]       if_instr;
   logic [31:0]       if_pc;
   logic              id_ready;
   logic [ADDR_W-1:0] addra;
   logic [ADDR_W-1:0] addrb;
   logic [DATA_W-1:0] rf_dataa;
   logic [DATA_W-1:0] rf_datab;
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_addr;
   logic              flush;
   logic              ex_valid;
   logic              ex_ready;
   logic [31:0]       ex_pc;
   logic [5:0]        ex_opcode;
   logic [5:0]        ex_funct;
   logic [4:0]        ex_shamt;
   logic [DATA_W-1:0] ex_rs_val;
   logic [DATA_W-1:0] ex_rt_val;
   logic [DATA_W-1:0] ex_imm;
   logic [ADDR_W-1:0] ex_dest;
   logic              ex_wr_en;
   logic              ex_illegal;
   modport slave (
      input  if_valid, if_instr, if_pc, rf_dataa, rf_datab, wb_valid, wb_addr, flush, ex_ready,
      output id_ready, addra, addrb, ex_valid, ex_pc, ex_opcode, ex_funct, ex_shamt,
             ex_rs_val, ex_rt_val, ex_imm, ex_dest, ex_wr_en, ex_illegal
   );
   modport master (
      output if_valid, if_instr, if_pc, rf_dataa, rf_datab, wb_valid, wb_addr, flush, ex_ready,
      input  id_ready, addra, addrb, ex_valid, ex_pc, ex_opcode, ex_funct, ex_shamt,
             ex_rs_val, ex_rt_val, ex_imm, ex_dest, ex_wr_en, ex_illegal
   );
endinterface

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: MIPS decode with register-bank address drive, operand hold and RAW/WAW scoreboard.
module instr_decode_stage #(
   parameter int REG_COUNT = 32,
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 32
) (
   input logic clock,
   input logic reset,
   instr_decode_stage_if.slave bus
);
   logic [5:0]        op, funct;
   logic [ADDR_W-1:0] rs, rt, rd, dest;
   logic              uses_rs, uses_rt, wr_raw, wr_en, illegal, hazard, ready, accept, zext;
   logic [15:0]       imm16;
   logic [DATA_W-1:0] imm;
   logic [REG_COUNT-1:0] pending, pend_nxt;
   logic              ex_valid, fresh, ex_wr_en, ex_illegal;
   logic [31:0]       ex_pc;
   logic [5:0]        ex_opcode, ex_funct;
   logic [4:0]        ex_shamt;
   logic [DATA_W-1:0] ex_imm, hold_a, hold_b;
   logic [ADDR_W-1:0] ex_dest;
   assign op    = bus.if_instr[31:26];
   assign rs    = bus.if_instr[25:21];
   assign rt    = bus.if_instr[20:16];
   assign rd    = bus.if_instr[15:11];
   assign funct = bus.if_instr[5:0];
   assign imm16 = bus.if_instr[15:0];
   always_comb begin
      uses_rs = 1'b0;
      uses_rt = 1'b0;
      dest    = rt;
      wr_raw  = 1'b0;
      illegal = 1'b0;
      case (op)
         6'h00: begin
            uses_rs = 1'b1;
            uses_rt = 1'b1;
            dest    = rd;
            wr_raw  = funct != 6'h08;
         end
         6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h23: begin
            uses_rs = 1'b1;
            wr_raw  = 1'b1;
         end
         6'h0F: wr_raw = 1'b1;
         6'h2B, 6'h04, 6'h05: begin
            uses_rs = 1'b1;
            uses_rt = 1'b1;
         end
         6'h02: wr_raw = 1'b0;
         6'h03: begin
            dest   = '1;
            wr_raw = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end
   assign wr_en  = wr_raw & (dest != '0);
   assign zext   = (op == 6'h0C) | (op == 6'h0D);
   assign imm    = {{(DATA_W-16){imm16[15] & ~zext}}, imm16};
   // WAW term keeps at most one in-flight write per register
   assign hazard = bus.if_valid & ((uses_rs & pending[rs]) | (uses_rt & pending[rt]) | (wr_en & pending[dest]));
   assign ready  = ~hazard & (~ex_valid | bus.ex_ready) & ~bus.flush;
   assign accept = bus.if_valid & ready;
   always_comb begin
      pend_nxt = pending;
      if (bus.wb_valid) pend_nxt[bus.wb_addr] = 1'b0;
      if (bus.flush & ex_valid & ex_wr_en) pend_nxt[ex_dest] = 1'b0;
      if (accept & wr_en) pend_nxt[dest] = 1'b1;
      pend_nxt[0] = 1'b0;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending    <= '0;
         ex_valid   <= 1'b0;
         fresh      <= 1'b0;
         hold_a     <= '0;
         hold_b     <= '0;
         ex_pc      <= '0;
         ex_opcode  <= '0;
         ex_funct   <= '0;
         ex_shamt   <= '0;
         ex_imm     <= '0;
         ex_dest    <= '0;
         ex_wr_en   <= 1'b0;
         ex_illegal <= 1'b0;
      end else begin
         pending <= pend_nxt;
         fresh   <= accept;
         // bank data is only valid the cycle after acceptance, so latch it then
         if (fresh) begin
            hold_a <= bus.rf_dataa;
            hold_b <= bus.rf_datab;
         end
         if (accept) begin
            ex_valid   <= 1'b1;
            ex_pc      <= bus.if_pc;
            ex_opcode  <= op;
            ex_funct   <= funct;
            ex_shamt   <= bus.if_instr[10:6];
            ex_imm     <= imm;
            ex_dest    <= dest;
            ex_wr_en   <= wr_en;
            ex_illegal <= illegal;
         end else if (bus.flush | bus.ex_ready) begin
            ex_valid <= 1'b0;
         end
      end
   end
   assign bus.id_ready   = ready;
   assign bus.addra      = rs;
   assign bus.addrb      = rt;
   assign bus.ex_valid   = ex_valid;
   assign bus.ex_pc      = ex_pc;
   assign bus.ex_opcode  = ex_opcode;
   assign bus.ex_funct   = ex_funct;
   assign bus.ex_shamt   = ex_shamt;
   assign bus.ex_rs_val  = fresh ? bus.rf_dataa : hold_a;
   assign bus.ex_rt_val  = fresh ? bus.rf_datab : hold_b;
   assign bus.ex_imm     = ex_imm;
   assign bus.ex_dest    = ex_dest;
   assign bus.ex_wr_en   = ex_wr_en;
   assign bus.ex_illegal = ex_illegal;
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed checks of decode, scoreboard stalls, backpressure, flush and reset.
module tb_instr_decode_stage;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int tests = 0;
   int fails = 0;
   instr_decode_stage_if bus ();
   instr_decode_stage dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic wb(input logic [4:0] a);
      bus.wb_valid = 1'b1;
      bus.wb_addr  = a;
      tick();
      bus.wb_valid = 1'b0;
   endtask

   task automatic test_reset;
      bus.if_valid = 0; bus.if_instr = 0; bus.if_pc = 0; bus.rf_dataa = 0; bus.rf_datab = 0;
      bus.wb_valid = 0; bus.wb_addr = 0; bus.flush = 0; bus.ex_ready = 1;
      #12;
      tests++; if (bus.ex_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0h want 0", bus.ex_valid); end
      tests++; if (bus.ex_imm !== 32'h0) begin fails++; $display("FAIL reset_imm: got %h want 0", bus.ex_imm); end
      reset = 1'b0;
      tick();
      tests++; if (bus.id_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0h want 1", bus.id_ready); end
   endtask

   task automatic test_accept;
      bus.if_valid = 1; bus.if_instr = 32'h20010005; bus.if_pc = 32'h100;
      #1;
      tests++; if (bus.addrb !== 5'd1 || bus.addra !== 5'd0) begin fails++; $display("FAIL accept_addr: got %0d/%0d want 0/1", bus.addra, bus.addrb); end
      tick();
      bus.if_valid = 0; bus.rf_dataa = 0;
      #1;
      tests++; if (bus.ex_valid !== 1'b1) begin fails++; $display("FAIL accept_valid: got %0h want 1", bus.ex_valid); end
      tests++; if (bus.ex_dest !== 5'd1 || bus.ex_wr_en !== 1'b1) begin fails++; $display("FAIL accept_dest: got %0d/%0h want 1/1", bus.ex_dest, bus.ex_wr_en); end
      tests++; if (bus.ex_imm !== 32'h5 || bus.ex_opcode !== 6'h08 || bus.ex_pc !== 32'h100) begin fails++; $display("FAIL accept_fields: got imm %h op %h pc %h want 5/08/100", bus.ex_imm, bus.ex_opcode, bus.ex_pc); end
      tick();
   endtask

   task automatic test_raw_stall;
      bus.if_valid = 1; bus.if_instr = 32'h00211020; bus.if_pc = 32'h104;
      #1;
      tests++; if (bus.id_ready !== 1'b0) begin fails++; $display("FAIL raw_stall0: got %0h want 0", bus.id_ready); end
      tick();
      tests++; if (bus.id_ready !== 1'b0) begin fails++; $display("FAIL raw_stall1: got %0h want 0", bus.id_ready); end
      bus.wb_valid = 1; bus.wb_addr = 1;
      #1;
      tests++; if (bus.id_ready !== 1'b0) begin fails++; $display("FAIL raw_wb_cycle: got %0h want 0", bus.id_ready); end
      tick();
      bus.wb_valid = 0;
      #1;
      tests++; if (bus.id_ready !== 1'b1) begin fails++; $display("FAIL raw_release: got %0h want 1", bus.id_ready); end
      tick();
      bus.if_valid = 0;
      #1;
      tests++; if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd2 || bus.ex_funct !== 6'h20) begin fails++; $display("FAIL raw_bundle: got v%0h d%0d f%h want v1 d2 f20", bus.ex_valid, bus.ex_dest, bus.ex_funct); end
      tick();
      wb(5'd2);
   endtask

   task automatic test_backpressure;
      bus.ex_ready = 0;
      bus.if_valid = 1; bus.if_instr = 32'h20A40007; bus.if_pc = 32'h200;
      tick();
      bus.if_instr = 32'h20060001; bus.if_pc = 32'h204; bus.rf_dataa = 32'hDEADBEEF;
      #1;
      tests++; if (bus.ex_rs_val !== 32'hDEADBEEF) begin fails++; $display("FAIL bp_fresh: got %h want deadbeef", bus.ex_rs_val); end
      tick();
      bus.rf_dataa = 32'h12345678;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++; if (bus.ex_rs_val !== 32'hDEADBEEF || bus.id_ready !== 1'b0 || bus.ex_valid !== 1'b1) begin fails++; $display("FAIL bp_hold%0d: got %h r%0h v%0h want deadbeef r0 v1", i, bus.ex_rs_val, bus.id_ready, bus.ex_valid); end
         tick();
      end
      bus.ex_ready = 1;
      #1;
      tests++; if (bus.id_ready !== 1'b1) begin fails++; $display("FAIL bp_release: got %0h want 1", bus.id_ready); end
      tick();
      bus.if_valid = 0;
      #1;
      tests++; if (bus.ex_dest !== 5'd6 || bus.ex_rs_val !== 32'h12345678) begin fails++; $display("FAIL bp_next: got d%0d %h want d6 12345678", bus.ex_dest, bus.ex_rs_val); end
      tick();
      wb(5'd4);
      wb(5'd6);
   endtask

   task automatic test_imm;
      bus.if_valid = 1; bus.if_instr = 32'h3402FFFF;
      tick();
      bus.if_valid = 0;
      tests++; if (bus.ex_imm !== 32'h0000FFFF || bus.ex_dest !== 5'd2) begin fails++; $display("FAIL imm_ori: got %h d%0d want 0000ffff d2", bus.ex_imm, bus.ex_dest); end
      tick();
      wb(5'd2);
      bus.if_valid = 1; bus.if_instr = 32'h2002FFFF;
      tick();
      bus.if_valid = 0;
      tests++; if (bus.ex_imm !== 32'hFFFFFFFF) begin fails++; $display("FAIL imm_addi: got %h want ffffffff", bus.ex_imm); end
      tick();
      wb(5'd2);
      bus.if_valid = 1; bus.if_instr = 32'h20000001;
      tick();
      bus.if_valid = 0;
      tests++; if (bus.ex_wr_en !== 1'b0 || bus.ex_dest !== 5'd0) begin fails++; $display("FAIL imm_r0: got w%0h d%0d want w0 d0", bus.ex_wr_en, bus.ex_dest); end
      tick();
   endtask

   task automatic test_flush;
      bus.ex_ready = 0;
      bus.if_valid = 1; bus.if_instr = 32'h20030009;
      tick();
      bus.if_instr = 32'h00631020;
      #1;
      tests++; if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd3 || bus.id_ready !== 1'b0) begin fails++; $display("FAIL flush_pre: got v%0h d%0d r%0h want v1 d3 r0", bus.ex_valid, bus.ex_dest, bus.id_ready); end
      bus.flush = 1;
      #1;
      tests++; if (bus.id_ready !== 1'b0) begin fails++; $display("FAIL flush_ready: got %0h want 0", bus.id_ready); end
      tick();
      bus.flush = 0;
      #1;
      tests++; if (bus.ex_valid !== 1'b0 || bus.id_ready !== 1'b1) begin fails++; $display("FAIL flush_post: got v%0h r%0h want v0 r1", bus.ex_valid, bus.id_ready); end
      bus.ex_ready = 1;
      tick();
      bus.if_valid = 0;
      tests++; if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd2) begin fails++; $display("FAIL flush_next: got v%0h d%0d want v1 d2", bus.ex_valid, bus.ex_dest); end
      tick();
      wb(5'd2);
      bus.if_valid = 1; bus.if_instr = 32'hFC430000;
      tick();
      bus.if_valid = 0;
      tests++; if (bus.ex_illegal !== 1'b1 || bus.ex_wr_en !== 1'b0) begin fails++; $display("FAIL illegal: got i%0h w%0h want i1 w0", bus.ex_illegal, bus.ex_wr_en); end
      tick();
   endtask

   task automatic test_back_to_back;
      bus.if_valid = 1; bus.if_instr = 32'h20070001;
      tick();
      bus.if_instr = 32'h20080002;
      #1;
      tests++; if (bus.id_ready !== 1'b1 || bus.ex_dest !== 5'd7) begin fails++; $display("FAIL b2b_first: got r%0h d%0d want r1 d7", bus.id_ready, bus.ex_dest); end
      tick();
      bus.if_instr = 32'h0C000000;
      #1;
      tests++; if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd8) begin fails++; $display("FAIL b2b_second: got v%0h d%0d want v1 d8", bus.ex_valid, bus.ex_dest); end
      tick();
      bus.if_valid = 0;
      tests++; if (bus.ex_dest !== 5'd31 || bus.ex_wr_en !== 1'b1 || bus.ex_illegal !== 1'b0) begin fails++; $display("FAIL jal: got d%0d w%0h i%0h want d31 w1 i0", bus.ex_dest, bus.ex_wr_en, bus.ex_illegal); end
      tick();
      wb(5'd7);
      wb(5'd8);
      wb(5'd31);
   endtask

   task automatic test_reset_midstream;
      bus.ex_ready = 0;
      bus.if_valid = 1; bus.if_instr = 32'h20010005;
      tick();
      bus.if_valid = 0; bus.rf_dataa = 32'hCAFE0001;
      #2;
      reset = 1;
      #1;
      tests++; if (bus.ex_valid !== 1'b0 || bus.ex_dest !== 5'd0 || bus.ex_wr_en !== 1'b0 || bus.ex_imm !== 32'h0 || bus.ex_rs_val !== 32'h0) begin fails++; $display("FAIL async_reset: got v%0h d%0d w%0h imm %h rs %h want all 0", bus.ex_valid, bus.ex_dest, bus.ex_wr_en, bus.ex_imm, bus.ex_rs_val); end
      #1;
      reset = 0;
      bus.if_valid = 1; bus.if_instr = 32'h00211020;
      #1;
      tests++; if (bus.id_ready !== 1'b1) begin fails++; $display("FAIL reset_scoreboard: got %0h want 1", bus.id_ready); end
      bus.if_valid = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_accept();
      test_raw_stall();
      test_backpressure();
      test_imm();
      test_flush();
      test_back_to_back();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
